// File: rtl/ro_meas_pkg.sv
// Shared types and default widths for the ring-oscillator measurement blocks.
// No logic of its own.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W_DEF       = 16;
    localparam int GATE_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/ro_freq_counter_if.sv
// Request/result bundle for one frequency-counter instance; the oscillator tap
// travels with it so each tap's measurement is a single connection.
interface ro_freq_counter_if
    import ro_meas_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GATE_W = GATE_W_DEF
);
    logic              start;
    logic [GATE_W-1:0] gate_cycles;
    logic              ro_in;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output start, gate_cycles, ro_in,
        input  busy, done, count, overflow
    );

    modport slave (
        input  start, gate_cycles, ro_in,
        output busy, done, count, overflow
    );
endinterface

// File: rtl/ro_edge_sync.sv
// Brings an asynchronous oscillator tap into clk and flags its rising edges.
// rise is a one-cycle pulse SYNC_STAGES cycles after the raw edge; no backpressure.
module ro_edge_sync
    import ro_meas_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ro_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // prev follows sync_out in every state, so a level already high at arm time
    // never looks like a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Counts synchronised ro_in rising edges over gate_cycles clk cycles; done pulses
// gate_q+2 cycles after start is taken (2 when gate_q==0); start ignored while busy.
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GATE_W      = GATE_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    ro_freq_counter_if.slave   bus
);

    state_t            state_q;
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [CNT_W-1:0]  edge_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              done_q;
    logic              busy_q;

    logic              rise;
    logic [CNT_W-1:0]  edge_nxt;
    logic              ovf_nxt;

    ro_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .ro_in (bus.ro_in),
        .rise  (rise)
    );

    // Saturating edge count; the final gate cycle's edge must reach count directly.
    always_comb begin
        edge_nxt = edge_q;
        ovf_nxt  = ovf_q;
        if (rise) begin
            if (edge_q == '1) begin
                ovf_nxt = 1'b1;
            end else begin
                edge_nxt = edge_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_q     <= '0;
            gate_cnt_q <= '0;
            edge_q     <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        gate_q  <= bus.gate_cycles;
                        edge_q  <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    if (gate_q == '0) begin
                        count_q    <= edge_q;
                        overflow_q <= ovf_q;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        gate_cnt_q <= gate_q;
                        state_q    <= GATE;
                    end
                end
                GATE: begin
                    edge_q     <= edge_nxt;
                    ovf_q      <= ovf_nxt;
                    gate_cnt_q <= gate_cnt_q - 1'b1;
                    if (gate_cnt_q == GATE_W'(1)) begin
                        count_q    <= edge_nxt;
                        overflow_q <= ovf_nxt;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule
